// File: rtl/clk_div_sel_pkg.sv
// Shared types and defaults for the clock rate-select stage.
package clk_div_pkg;
  typedef enum logic [1:0] {SEL_OFF, SEL_DIV2, SEL_DIV4, SEL_DIV6} div_sel_e;
  typedef enum logic {ST_RUN, ST_WAIT} sel_state_e;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/clk_div_sel_if.sv
// Rate-change request handshake between requester and clk_div_sel.
interface clk_div_sel_if;
  logic [1:0] sel;
  logic       sel_valid;
  logic       sel_ready;

  modport master (output sel, output sel_valid, input sel_ready);
  modport slave  (input sel, input sel_valid, output sel_ready);
endinterface

// File: rtl/clk_div_edge_det.sv
// Registered output stage plus one-cycle tick on each rising edge of out.
module clk_div_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic nxt,
  output logic out,
  output logic tick
);
  logic out_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out   <= 1'b0;
      out_q <= 1'b0;
    end else begin
      out   <= nxt;
      out_q <= out;
    end
  end

  // Both terms are flops, so tick is glitch-free and coincides with out's first high cycle.
  assign tick = out & ~out_q;
endmodule

// File: rtl/clk_div_sel.sv
// Glitch-free selection of div2/div4/div6 onto one registered output.
// Optional tick counter enabled by defining CLK_DIV_SEL_CNT_EN.
module clk_div_sel
  import clk_div_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div2,
  input  logic             div4,
  input  logic             div6,
  clk_div_sel_if.slave     req,
  output logic             out,
  output logic             tick,
  output logic [1:0]       cur_sel,
  output logic             busy,
  output logic             force_err,
  output logic [CNT_W-1:0] tick_cnt
);
  localparam int WC_W = $clog2(TIMEOUT);

  logic [3:0] src;
  sel_state_e state, state_n;
  div_sel_e   cur, cur_n, pend, pend_n;
  logic       busy_n, ferr_n;
  logic [WC_W-1:0] wait_cnt, wait_n;

  assign src           = {div6, div4, div2, 1'b0};
  assign req.sel_ready = (state == ST_RUN);
  assign cur_sel       = cur;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_RUN;
      cur       <= SEL_OFF;
      pend      <= SEL_OFF;
      busy      <= 1'b0;
      force_err <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      pend      <= pend_n;
      busy      <= busy_n;
      force_err <= ferr_n;
      wait_cnt  <= wait_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    pend_n  = pend;
    busy_n  = busy;
    ferr_n  = force_err;
    wait_n  = wait_cnt;
    case (state)
      ST_RUN: begin
        if (req.sel_valid) begin
          pend_n = div_sel_e'(req.sel);
          wait_n = '0;
          if (req.sel != 2'(cur)) begin
            state_n = ST_WAIT;
            busy_n  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Swap only while both sources are low so out never shows a runt pulse.
        if (!src[cur] && !src[pend]) begin
          cur_n   = pend;
          busy_n  = 1'b0;
          state_n = ST_RUN;
        end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
          cur_n   = pend;
          busy_n  = 1'b0;
          ferr_n  = 1'b1;
          state_n = ST_RUN;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  clk_div_edge_det u_edge (
    .clk    (clk),
    .resetn (resetn),
    .nxt    (src[cur]),
    .out    (out),
    .tick   (tick)
  );

`ifdef CLK_DIV_SEL_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic             sw_done;

  assign sw_done = (state == ST_WAIT) && (state_n == ST_RUN);

  always_ff @(posedge clk) begin
    if (!resetn || sw_done) cnt <= '0;
    else if (tick)          cnt <= cnt + 1'b1;
  end
  assign tick_cnt = cnt;
`else
  assign tick_cnt = '0;
`endif
endmodule

// File: tb/tb_clk_div_sel.sv
// Directed self-checking bench for clk_div_sel.
module tb_clk_div_sel;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic resetn, div2, div4, div6;
  logic out, tick, busy, force_err;
  logic [1:0] cur_sel;
  logic [CNT_W-1:0] tick_cnt;
  logic stuck;
  int   t, last;
  int   checks = 0, errors = 0;

  clk_div_sel_if req_if ();

  clk_div_sel #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .div2      (div2),
    .div4      (div4),
    .div6      (div6),
    .req       (req_if.slave),
    .out       (out),
    .tick      (tick),
    .cur_sel   (cur_sel),
    .busy      (busy),
    .force_err (force_err),
    .tick_cnt  (tick_cnt)
  );

  always #5 clk = ~clk;

  // Divider phase model: div2 high at odd t, div4 at t%4>=2, div6 at t%6>=3.
  task automatic step();
    div2 = (t % 2) == 1;
    div4 = stuck | ((t % 4) >= 2);
    div6 = stuck | ((t % 6) >= 3);
    @(posedge clk);
    #1;
    last = t;
    t++;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, last, got, exp);
    end
  endtask

  initial begin
    t = 0; last = 0; stuck = 1'b0;
    resetn = 1'b0;
    req_if.sel = 2'd0; req_if.sel_valid = 1'b0;

    repeat (3) step();
    chk("rst_out", 16'(out), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    resetn = 1'b1;
    step();                                   // t3
    chk("init_out", 16'(out), 16'd0);
    chk("init_tick", 16'(tick), 16'd0);
    chk("init_cur", 16'(cur_sel), 16'd0);
    chk("init_ready", 16'(req_if.sel_ready), 16'd1);
    chk("init_busy", 16'(busy), 16'd0);
    chk("init_ferr", 16'(force_err), 16'd0);
    chk("init_cnt", 16'(tick_cnt), 16'd0);
    step();                                   // t4

    // 0 -> div2: div2 low at t6, so busy lasts one cycle
    req_if.sel = 2'd1; req_if.sel_valid = 1'b1;
    step();                                   // t5
    req_if.sel_valid = 1'b0;
    chk("s1_busy", 16'(busy), 16'd1);
    chk("s1_ready", 16'(req_if.sel_ready), 16'd0);
    chk("s1_cur_old", 16'(cur_sel), 16'd0);
    step();                                   // t6
    chk("s1_done", 16'(busy), 16'd0);
    chk("s1_cur", 16'(cur_sel), 16'd1);
    chk("s1_out", 16'(out), 16'd0);
    for (int k = 0; k < 6; k++) begin        // t7..12
      step();
      chk("div2_out", 16'(out), 16'(last % 2));
      chk("div2_tick", 16'(tick), 16'(last % 2));
    end

    // div2 -> div6 at t%6=1: first common low is t14
    req_if.sel = 2'd3; req_if.sel_valid = 1'b1;
    step();                                   // t13
    req_if.sel_valid = 1'b0;
    chk("s3_busy", 16'(busy), 16'd1);
    chk("s3_out_hi", 16'(out), 16'd1);
    step();                                   // t14
    chk("s3_done", 16'(busy), 16'd0);
    chk("s3_cur", 16'(cur_sel), 16'd3);
    chk("s3_out_lo", 16'(out), 16'd0);
    for (int k = 0; k < 12; k++) begin       // t15..26
      step();
      chk("div6_out", 16'((last % 6) >= 3), 16'(out));
      chk("div6_tick", 16'(tick), 16'((last % 6) == 3));
    end

    // div6 -> div4: first common low is t32
    req_if.sel = 2'd2; req_if.sel_valid = 1'b1;
    step();                                   // t27
    req_if.sel_valid = 1'b0;
    repeat (4) step();                        // t28..31
    chk("s2_wait", 16'(busy), 16'd1);
    chk("s2_cur_old", 16'(cur_sel), 16'd3);
    step();                                   // t32
    chk("s2_done", 16'(busy), 16'd0);
    chk("s2_cur", 16'(cur_sel), 16'd2);
    chk("s2_ferr", 16'(force_err), 16'd0);

    // stuck div4/div6: forced switch on the 16th WAIT edge (t49)
    stuck = 1'b1;
    req_if.sel = 2'd3; req_if.sel_valid = 1'b1;
    step();                                   // t33
    req_if.sel_valid = 1'b0;
    repeat (15) step();                       // t34..48
    chk("to_busy", 16'(busy), 16'd1);
    chk("to_cur_old", 16'(cur_sel), 16'd2);
    chk("to_ferr_pre", 16'(force_err), 16'd0);
    chk("to_ready_pre", 16'(req_if.sel_ready), 16'd0);
    step();                                   // t49
    chk("to_cur", 16'(cur_sel), 16'd3);
    chk("to_ferr", 16'(force_err), 16'd1);
    chk("to_ready", 16'(req_if.sel_ready), 16'd1);
    chk("to_busy_clr", 16'(busy), 16'd0);

    // reset while waiting (div6 high at t51)
    stuck = 1'b0;
    req_if.sel = 2'd1; req_if.sel_valid = 1'b1;
    step();                                   // t50
    req_if.sel_valid = 1'b0;
    chk("rw_busy", 16'(busy), 16'd1);
    step();                                   // t51
    chk("rw_ferr_sticky", 16'(force_err), 16'd1);
    resetn = 1'b0;
    step();                                   // t52
    chk("rw_busy_clr", 16'(busy), 16'd0);
    chk("rw_cur", 16'(cur_sel), 16'd0);
    chk("rw_out", 16'(out), 16'd0);
    chk("rw_ready", 16'(req_if.sel_ready), 16'd1);
    chk("rw_ferr", 16'(force_err), 16'd0);
    resetn = 1'b1;
    step(); step();                           // t53,54
    chk("rw_drop_cur", 16'(cur_sel), 16'd0);
    chk("rw_drop_busy", 16'(busy), 16'd0);
    chk("rw_drop_out", 16'(out), 16'd0);

`ifdef CLK_DIV_SEL_CNT_EN
    req_if.sel = 2'd1; req_if.sel_valid = 1'b1;
    step();                                   // t55
    req_if.sel_valid = 1'b0;
    step();                                   // t56
    chk("cnt_cur", 16'(cur_sel), 16'd1);
    chk("cnt_start", 16'(tick_cnt), 16'd0);
    for (int k = 0; k < 40; k++) begin       // t57..96, wraps at t88
      step();
      chk("cnt_run", 16'(tick_cnt), 16'(((last - 56) / 2) % 16));
    end
    req_if.sel = 2'd2; req_if.sel_valid = 1'b1;
    step();                                   // t97
    req_if.sel_valid = 1'b0;
    step(); step();                           // t98,99
    chk("cnt_wait_busy", 16'(busy), 16'd1);
    step();                                   // t100
    chk("cnt_sw_cur", 16'(cur_sel), 16'd2);
    chk("cnt_sw_clr", 16'(tick_cnt), 16'd0);
    step();                                   // t101
    chk("cnt_sw_hold", 16'(tick_cnt), 16'd0);
`else
    req_if.sel = 2'd1; req_if.sel_valid = 1'b1;
    step();
    req_if.sel_valid = 1'b0;
    repeat (6) step();
    chk("cnt_tied", 16'(tick_cnt), 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
